// File: rtl/event_timestamper_v2.sv
// Event timestamper: start/end handshakes stamped from a free-running counter,
// closed, orphaned and timed-out intervals are queued as records in an output FIFO.
module event_timestamper_v2 #(
    parameter int ID_W       = 3,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [ID_W-1:0] start_id,
    input  logic            end_valid,
    output logic            end_ready,
    input  logic [ID_W-1:0] end_id,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_id,
    output logic [TS_W-1:0] out_start_ts,
    output logic [TS_W-1:0] out_end_ts,
    output logic [TS_W-1:0] out_delta,
    output logic [1:0]      out_status,
    output logic            err_dup_start
);

    localparam int N     = 1 << ID_W;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int REC_W = ID_W + 3 * TS_W + 2;

    localparam logic [TS_W-1:0] TMO  = TS_W'(TIMEOUT);
    localparam logic [AW:0]     FULL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_NOS = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;

    logic [TS_W-1:0]  cnt_q;
    logic [N-1:0]     active_q;
    logic [TS_W-1:0]  start_ts_q [N];
    logic [ID_W-1:0]  swp_q;
    logic             ready_q;
    logic             dup_q;
    logic [REC_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    logic             start_fire;
    logic             end_fire;
    logic             full;
    logic             pop;
    logic             push;
    logic             end_active;
    logic [TS_W-1:0]  end_start_ts;
    logic [TS_W-1:0]  swp_start_ts;
    logic [TS_W-1:0]  swp_age;
    logic             swp_hit;
    logic             tmo_push;
    logic             swp_hold;
    logic             dup;
    logic [REC_W-1:0] rec;

    assign full        = (count_q == FULL);
    assign start_ready = ready_q;
    assign end_ready   = ready_q & ~full;
    assign out_valid   = (count_q != '0);
    assign start_fire  = start_valid & ready_q;
    assign end_fire    = end_valid & end_ready;
    assign pop         = out_valid & out_ready;

    assign end_active   = active_q[end_id];
    assign end_start_ts = start_ts_q[end_id];
    assign swp_start_ts = start_ts_q[swp_q];
    assign swp_age      = cnt_q - swp_start_ts;

    // A start landing on the swept ID restarts it, so it never times out here.
    assign swp_hit  = (TIMEOUT != 0)
                    & active_q[swp_q]
                    & (swp_age >= TMO)
                    & ~(start_fire & (start_id == swp_q));
    assign tmo_push = swp_hit & ~end_fire & ~full;
    assign swp_hold = swp_hit & ~tmo_push;
    assign push     = end_fire | tmo_push;

    // A same-cycle end on the same ID closes the entry, so no duplicate.
    assign dup = start_fire
               & active_q[start_id]
               & ~(end_fire & (end_id == start_id));

    always_comb begin
        rec = '0;
        unique case (1'b1)
            end_fire & end_active: begin
                rec = {end_id, end_start_ts, cnt_q,
                       cnt_q - end_start_ts, ST_OK};
            end
            end_fire & ~end_active: begin
                rec = {end_id, TS_W'(0), cnt_q,
                       TS_W'(0), ST_NOS};
            end
            tmo_push: begin
                rec = {swp_q, swp_start_ts, cnt_q,
                       swp_age, ST_TMO};
            end
            default: rec = '0;
        endcase
    end

    assign {out_id, out_start_ts, out_end_ts,
            out_delta, out_status} = mem_q[rd_ptr_q];

    assign err_dup_start = dup_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= '0;
            swp_q    <= '0;
            ready_q  <= 1'b0;
            dup_q    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                start_ts_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_q + 1'b1;
            ready_q <= 1'b1;
            dup_q   <= dup;
            if (tmo_push) begin
                active_q[swp_q] <= 1'b0;
            end
            if (end_fire) begin
                active_q[end_id] <= 1'b0;
            end
            if (start_fire) begin
                active_q[start_id]   <= 1'b1;
                start_ts_q[start_id] <= cnt_q;
            end
            if (!swp_hold) begin
                swp_q <= swp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= rec;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_event_timestamper_v2.sv
// Directed bench for event_timestamper_v2: one instance with the sweep off,
// one with TIMEOUT=20 for the abandoned-ID case.
module tb_event_timestamper_v2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tcnt;

    logic       s_v = 1'b0, e_v = 1'b0, o_rdy = 1'b1;
    logic [2:0] s_id = '0, e_id = '0;
    logic       s_rdy, e_rdy, o_v, dup;
    logic [2:0] o_id;
    logic [7:0] o_st, o_en, o_dl;
    logic [1:0] o_stat;

    logic       b_s_v = 1'b0, b_e_v = 1'b0, b_o_rdy = 1'b1;
    logic [2:0] b_s_id = '0, b_e_id = '0;
    logic       b_s_rdy, b_e_rdy, b_o_v, b_dup;
    logic [2:0] b_o_id;
    logic [7:0] b_o_st, b_o_en, b_o_dl;
    logic [1:0] b_o_stat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt <= '0;
        else        tcnt <= tcnt + 8'd1;
    end

    event_timestamper_v2 #(
        .ID_W(3), .TS_W(8), .FIFO_DEPTH(4), .TIMEOUT(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .start_valid(s_v), .start_ready(s_rdy), .start_id(s_id),
        .end_valid(e_v), .end_ready(e_rdy), .end_id(e_id),
        .out_valid(o_v), .out_ready(o_rdy), .out_id(o_id),
        .out_start_ts(o_st), .out_end_ts(o_en), .out_delta(o_dl),
        .out_status(o_stat), .err_dup_start(dup)
    );

    event_timestamper_v2 #(
        .ID_W(3), .TS_W(8), .FIFO_DEPTH(4), .TIMEOUT(20)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .start_valid(b_s_v), .start_ready(b_s_rdy), .start_id(b_s_id),
        .end_valid(b_e_v), .end_ready(b_e_rdy), .end_id(b_e_id),
        .out_valid(b_o_v), .out_ready(b_o_rdy), .out_id(b_o_id),
        .out_start_ts(b_o_st), .out_end_ts(b_o_en), .out_delta(b_o_dl),
        .out_status(b_o_stat), .err_dup_start(b_dup)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input logic [2:0] id,
                           input logic [7:0] st, input logic [7:0] en,
                           input logic [7:0] dl, input logic [1:0] stat);
        chk({tag, ".valid"}, 32'(o_v), 32'd1);
        chk({tag, ".id"}, 32'(o_id), 32'(id));
        chk({tag, ".start"}, 32'(o_st), 32'(st));
        chk({tag, ".end"}, 32'(o_en), 32'(en));
        chk({tag, ".delta"}, 32'(o_dl), 32'(dl));
        chk({tag, ".status"}, 32'(o_stat), 32'(stat));
    endtask

    task automatic wait_cnt(input logic [7:0] v);
        for (int i = 0; i < 300 && tcnt != v; i++) @(negedge clk);
        if (tcnt != v) chk("wait_cnt", 32'(tcnt), 32'(v));
    endtask

    task automatic do_start(input logic [2:0] id);
        s_v = 1'b1; s_id = id;
        @(negedge clk);
        s_v = 1'b0;
    endtask

    task automatic do_end(input logic [2:0] id);
        e_v = 1'b1; e_id = id;
        @(negedge clk);
        e_v = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ts [4];
        logic [7:0] t5;
        logic [7:0] d;
        int extra;

        repeat (3) @(negedge clk);
        chk("rst.out_valid", 32'(o_v), 32'd0);
        chk("rst.start_ready", 32'(s_rdy), 32'd0);
        chk("rst.end_ready", 32'(e_rdy), 32'd0);
        chk("rst.err_dup", 32'(dup), 32'd0);
        chk("rst.out_id", 32'(o_id), 32'd0);
        chk("rst.out_delta", 32'(o_dl), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel.start_ready", 32'(s_rdy), 32'd1);
        chk("rel.end_ready", 32'(e_rdy), 32'd1);
        chk("rel.out_valid", 32'(o_v), 32'd0);

        wait_cnt(8'd5);   do_start(3'd2);
        wait_cnt(8'd17);  do_end(3'd2);
        chk_rec("basic", 3'd2, 8'd5, 8'd17, 8'd12, 2'b00);
        @(negedge clk);
        chk("basic.popped", 32'(o_v), 32'd0);

        wait_cnt(8'd250); do_start(3'd1);
        wait_cnt(8'd4);   do_end(3'd1);
        chk_rec("wrap", 3'd1, 8'd250, 8'd4, 8'd10, 2'b00);

        wait_cnt(8'd8);   do_end(3'd6);
        chk_rec("orphan", 3'd6, 8'd0, 8'd8, 8'd0, 2'b01);

        wait_cnt(8'd10);  do_start(3'd3);
        chk("dup.first", 32'(dup), 32'd0);
        wait_cnt(8'd20);  do_start(3'd3);
        chk("dup.pulse", 32'(dup), 32'd1);
        @(negedge clk);
        chk("dup.one_cycle", 32'(dup), 32'd0);
        wait_cnt(8'd30);  do_end(3'd3);
        chk_rec("dup", 3'd3, 8'd20, 8'd30, 8'd10, 2'b00);

        wait_cnt(8'd40);  do_start(3'd4);
        wait_cnt(8'd50);
        s_v = 1'b1; s_id = 3'd4; e_v = 1'b1; e_id = 3'd4;
        @(negedge clk);
        s_v = 1'b0; e_v = 1'b0;
        chk_rec("same", 3'd4, 8'd40, 8'd50, 8'd10, 2'b00);
        chk("same.no_dup", 32'(dup), 32'd0);
        wait_cnt(8'd60);  do_end(3'd4);
        chk_rec("same.restart", 3'd4, 8'd50, 8'd60, 8'd10, 2'b00);

        wait_cnt(8'd70);
        o_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ts[i] = tcnt;
            do_start(3'(i));
            do_end(3'(i));
        end
        chk("bp.end_ready_low", 32'(e_rdy), 32'd0);
        chk_rec("bp.head", 3'd0, ts[0], ts[0] + 8'd1, 8'd1, 2'b00);
        e_v = 1'b1; e_id = 3'd5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp.held_ready", 32'(e_rdy), 32'd0);
            chk("bp.hold_id", 32'(o_id), 32'd0);
            chk("bp.hold_start", 32'(o_st), 32'(ts[0]));
        end
        o_rdy = 1'b1;
        @(negedge clk);
        chk("bp.pop1", 32'(o_id), 32'd1);
        chk("bp.pop1_end", 32'(o_en), 32'(ts[1] + 8'd1));
        chk("bp.ready_back", 32'(e_rdy), 32'd1);
        t5 = tcnt;
        @(negedge clk);
        e_v = 1'b0;
        chk("bp.pop2", 32'(o_id), 32'd2);
        @(negedge clk);
        chk("bp.pop3", 32'(o_id), 32'd3);
        @(negedge clk);
        chk_rec("bp.fifth", 3'd5, 8'd0, t5, 8'd0, 2'b01);
        @(negedge clk);
        chk("bp.drained", 32'(o_v), 32'd0);

        wait_cnt(8'd0);
        b_s_v = 1'b1; b_s_id = 3'd0;
        @(negedge clk);
        b_s_v = 1'b0;
        for (int i = 0; i < 40 && !b_o_v; i++) @(negedge clk);
        d = b_o_dl;
        chk("tmo.valid", 32'(b_o_v), 32'd1);
        chk("tmo.id", 32'(b_o_id), 32'd0);
        chk("tmo.status", 32'(b_o_stat), 32'd2);
        chk("tmo.start", 32'(b_o_st), 32'd0);
        chk("tmo.end_eq_delta", 32'(b_o_en), 32'(d));
        chk("tmo.delta_range", 32'(d >= 8'd20 && d <= 8'd27), 32'd1);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (b_o_v) extra++;
        end
        chk("tmo.single", 32'(extra), 32'd0);
        b_e_v = 1'b1; b_e_id = 3'd0;
        @(negedge clk);
        b_e_v = 1'b0;
        chk("tmo.after_valid", 32'(b_o_v), 32'd1);
        chk("tmo.after_status", 32'(b_o_stat), 32'd1);

        @(negedge clk);
        o_rdy = 1'b0;
        do_start(3'd7);
        do_start(3'd5);
        do_end(3'd5);
        do_end(3'd6);
        chk("ar.queued", 32'(o_v), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.out_valid", 32'(o_v), 32'd0);
        chk("ar.out_id", 32'(o_id), 32'd0);
        chk("ar.out_start", 32'(o_st), 32'd0);
        chk("ar.out_end", 32'(o_en), 32'd0);
        chk("ar.out_status", 32'(o_stat), 32'd0);
        chk("ar.start_ready", 32'(s_rdy), 32'd0);
        chk("ar.end_ready", 32'(e_rdy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        o_rdy = 1'b1;
        t5 = tcnt;
        do_end(3'd7);
        chk_rec("ar.orphan", 3'd7, 8'd0, t5, 8'd0, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
